// File: rtl/ocx_tlx_arbq_pkg.sv
// rtl/ocx_tlx_arbq_pkg.sv - shared constants and one-hot encoder for the TLX AXI arbitration queue.
package ocx_tlx_arbq_pkg;

  localparam int DEF_WIDTH = 64;
  localparam int CHAN_W    = 2;
  localparam int N         = 2**CHAN_W;
  localparam int PTR_W     = 2;

  function automatic int unsigned onehot_enc(input logic [31:0] oh);
    int unsigned b;
    b = 0;
    for (int i = 0; i < 32; i++) begin
      if (oh[i]) b = b | i;
    end
    return b;
  endfunction

endpackage

// File: rtl/ocx_tlx_arbq_fifo.sv
// rtl/ocx_tlx_arbq_fifo.sv - per-channel synchronous FIFO with first-word head output.
module ocx_tlx_arbq_fifo
  import ocx_tlx_arbq_pkg::*;
#(
  parameter int W     = DEF_WIDTH,
  parameter int DEPTH = 2**PTR_W
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0] r_mem [DEPTH];
  logic [PW:0]  r_wptr;
  logic [PW:0]  r_rptr;
  logic         w_wr;
  logic         w_rd;

  // Extra pointer MSB separates full from empty when the index bits match.
  assign full  = (r_wptr[PW] != r_rptr[PW]) && (r_wptr[PW-1:0] == r_rptr[PW-1:0]);
  assign empty = (r_wptr == r_rptr);
  assign head  = r_mem[r_rptr[PW-1:0]];
  assign w_wr  = push & ~full;
  assign w_rd  = pop & ~empty;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + (PW+1)'(1);
      if (w_rd) r_rptr <= r_rptr + (PW+1)'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (w_wr) r_mem[r_wptr[PW-1:0]] <= wdata;
  end

endmodule

// File: rtl/ocx_tlx_axi_arb_queue.sv
// rtl/ocx_tlx_axi_arb_queue.sv - per-channel FIFOs, round-robin arbiter and registered output stage.
// Optional entry parity checking enabled by OCX_TLX_ARBQ_PARITY_EN.
module ocx_tlx_axi_arb_queue
  import ocx_tlx_arbq_pkg::*;
#(
  parameter int BITS  = CHAN_W,
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = 2**PTR_W
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [2**BITS-1:0]       in_valid,
  output logic [2**BITS-1:0]       in_ready,
  input  logic [2**BITS*WIDTH-1:0] in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic [BITS-1:0]          out_chan
`ifdef OCX_TLX_ARBQ_PARITY_EN
  ,output logic                    parity_err
`endif
);

  localparam int NC = 2**BITS;
`ifdef OCX_TLX_ARBQ_PARITY_EN
  localparam int FW = WIDTH + 1;
`else
  localparam int FW = WIDTH;
`endif

  logic [NC-1:0]   w_full;
  logic [NC-1:0]   w_empty;
  logic [NC-1:0]   w_push;
  logic [NC-1:0]   w_pop;
  logic [NC-1:0]   w_req;
  logic [NC-1:0]   w_gnt_oh;
  logic [FW-1:0]   w_wdata [NC];
  logic [FW-1:0]   w_head  [NC];
  logic [BITS-1:0] w_gnt;
  logic            w_load;
  logic [BITS-1:0] r_last;
  logic [BITS-1:0] r_chan;
  logic [WIDTH-1:0] r_data;
  logic            r_valid;

  // Scan upward from the last winner; k == NC wraps back onto r_last itself.
  function automatic logic [NC-1:0] rr_pick(input logic [NC-1:0] req, input logic [BITS-1:0] last);
    logic [BITS-1:0] idx;
    rr_pick = '0;
    for (int k = 1; k <= NC; k++) begin
      idx = last + BITS'(k);
      if (rr_pick == '0 && req[idx]) rr_pick[idx] = 1'b1;
    end
  endfunction

  assign in_ready = ~w_full & {NC{~reset}};
  assign w_push   = in_valid & in_ready;
  assign w_req    = ~w_empty;
  assign w_gnt_oh = rr_pick(w_req, r_last);
  assign w_gnt    = BITS'(onehot_enc(32'(w_gnt_oh)));
  assign w_load   = (|w_req) & (~r_valid | out_ready);
  assign w_pop    = w_gnt_oh & {NC{w_load}};

  for (genvar g = 0; g < NC; g++) begin : g_chan
`ifdef OCX_TLX_ARBQ_PARITY_EN
    assign w_wdata[g] = {^in_data[g*WIDTH +: WIDTH], in_data[g*WIDTH +: WIDTH]};
`else
    assign w_wdata[g] = in_data[g*WIDTH +: WIDTH];
`endif
    ocx_tlx_arbq_fifo #(.W(FW), .DEPTH(DEPTH)) u_fifo (
      .clock (clock),
      .reset (reset),
      .push  (w_push[g]),
      .wdata (w_wdata[g]),
      .pop   (w_pop[g]),
      .full  (w_full[g]),
      .empty (w_empty[g]),
      .head  (w_head[g])
    );
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_chan  <= '0;
      r_last  <= '1;
    end else if (w_load) begin
      r_valid <= 1'b1;
      r_data  <= w_head[w_gnt][WIDTH-1:0];
      r_chan  <= w_gnt;
      r_last  <= w_gnt;
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end

`ifdef OCX_TLX_ARBQ_PARITY_EN
  logic r_parity_err;

  // Stored bit makes the entry even; any odd total means a corrupted entry.
  always_ff @(posedge clock) begin
    if (reset) r_parity_err <= 1'b0;
    else       r_parity_err <= w_load & (^w_head[w_gnt]);
  end

  assign parity_err = r_parity_err;
`endif

  assign out_valid = r_valid;
  assign out_data  = r_data;
  assign out_chan  = r_chan;

endmodule

// File: tb/tb_ocx_tlx_axi_arb_queue.sv
// tb/tb_ocx_tlx_axi_arb_queue.sv - directed vector bench for the TLX AXI arbitration queue.
module tb_ocx_tlx_axi_arb_queue;

  logic         clock;
  logic         reset;
  logic [3:0]   in_valid;
  logic [3:0]   in_ready;
  logic [255:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [63:0]  out_data;
  logic [1:0]   out_chan;
`ifdef OCX_TLX_ARBQ_PARITY_EN
  logic         parity_err;
`endif

  int n_vec;
  int n_err;

  ocx_tlx_axi_arb_queue #(.BITS(2), .WIDTH(64), .DEPTH(4)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_chan  (out_chan)
`ifdef OCX_TLX_ARBQ_PARITY_EN
    ,.parity_err (parity_err)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        rst;
    logic [3:0]  vld;
    logic [7:0]  dat;
    logic        ordy;
    logic        e_ov;
    logic [1:0]  e_ch;
    logic [15:0] e_d;
    logic [3:0]  e_rdy;
  } vec_t;

  vec_t tv [16];

  task automatic drive(input logic rst, input logic [3:0] vld, input logic [7:0] dat, input logic ordy);
    reset     = rst;
    in_valid  = vld;
    out_ready = ordy;
    for (int i = 0; i < 4; i++) in_data[i*64 +: 64] = {48'h0, 8'(i), dat};
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rst, input logic [3:0] vld, input logic [7:0] dat,
                              input logic ordy, input logic e_ov, input logic [1:0] e_ch,
                              input logic [15:0] e_d, input logic [3:0] e_rdy);
    vec_t v;
    v.rst = rst; v.vld = vld; v.dat = dat; v.ordy = ordy;
    v.e_ov = e_ov; v.e_ch = e_ch; v.e_d = e_d; v.e_rdy = e_rdy;
    return v;
  endfunction

  initial begin
    n_vec = 0;
    n_err = 0;
    drive(1'b1, 4'h0, 8'h00, 1'b1);

    // reset, single ch2 push, ch3 streaming, then ch0 joining
    tv[0]  = mk(1, 4'b0000, 8'h00, 1, 0, 0, 16'h0000, 4'b0000);
    tv[1]  = mk(1, 4'b0000, 8'h00, 1, 0, 0, 16'h0000, 4'b0000);
    tv[2]  = mk(0, 4'b0100, 8'hA5, 1, 0, 0, 16'h0000, 4'b1111);
    tv[3]  = mk(0, 4'b0000, 8'h00, 1, 1, 2, 16'h02A5, 4'b1111);
    tv[4]  = mk(0, 4'b0000, 8'h00, 1, 0, 2, 16'h02A5, 4'b1111);
    tv[5]  = mk(0, 4'b1000, 8'h10, 1, 0, 2, 16'h02A5, 4'b1111);
    tv[6]  = mk(0, 4'b1000, 8'h11, 1, 1, 3, 16'h0310, 4'b1111);
    tv[7]  = mk(0, 4'b1000, 8'h12, 1, 1, 3, 16'h0311, 4'b1111);
    tv[8]  = mk(0, 4'b1001, 8'h13, 1, 1, 3, 16'h0312, 4'b1111);
    tv[9]  = mk(0, 4'b1001, 8'h14, 1, 1, 0, 16'h0013, 4'b1111);
    tv[10] = mk(0, 4'b1001, 8'h15, 1, 1, 3, 16'h0313, 4'b1111);
    tv[11] = mk(0, 4'b0000, 8'h00, 1, 1, 0, 16'h0014, 4'b1111);
    tv[12] = mk(0, 4'b0000, 8'h00, 1, 1, 3, 16'h0314, 4'b1111);
    tv[13] = mk(0, 4'b0000, 8'h00, 1, 1, 0, 16'h0015, 4'b1111);
    tv[14] = mk(0, 4'b0000, 8'h00, 1, 1, 3, 16'h0315, 4'b1111);
    tv[15] = mk(0, 4'b0000, 8'h00, 1, 0, 3, 16'h0315, 4'b1111);

    for (int v = 0; v < 16; v++) begin
      drive(tv[v].rst, tv[v].vld, tv[v].dat, tv[v].ordy);
      tick();
      chk($sformatf("tv%0d out_valid", v), 64'(out_valid), 64'(tv[v].e_ov));
      chk($sformatf("tv%0d out_chan", v), 64'(out_chan), 64'(tv[v].e_ch));
      chk($sformatf("tv%0d out_data", v), out_data, {48'h0, tv[v].e_d});
      chk($sformatf("tv%0d in_ready", v), 64'(in_ready), 64'(tv[v].e_rdy));
    end

    // fill every channel with out_ready low; ch0 gives one entry to the output register
    for (int s = 0; s < 4; s++) begin
      drive(0, 4'b1111, 8'(s), 0);
      tick();
    end
    chk("fill in_ready", 64'(in_ready), 64'h1);
    drive(0, 4'b0001, 8'h04, 0);
    tick();
    chk("full in_ready", 64'(in_ready), 64'h0);
    chk("full out_valid", 64'(out_valid), 64'h1);

    // stall with offers on every channel: nothing accepted, output stable
    for (int c = 0; c < 10; c++) begin
      drive(0, 4'b1111, 8'h55, 0);
      tick();
      chk($sformatf("stall%0d in_ready", c), 64'(in_ready), 64'h0);
      chk($sformatf("stall%0d out_data", c), out_data, 64'h0);
      chk($sformatf("stall%0d out_chan", c), 64'(out_chan), 64'h0);
    end

    // release: round-robin from ch1, each channel in push order, one per cycle
    for (int k = 0; k < 16; k++) begin
      drive(0, 4'b0000, 8'h00, 1);
      tick();
      chk($sformatf("drain%0d out_valid", k), 64'(out_valid), 64'h1);
      chk($sformatf("drain%0d out_chan", k), 64'(out_chan), 64'((k + 1) % 4));
      chk($sformatf("drain%0d out_data", k), out_data, {48'h0, 8'((k + 1) % 4), 8'((k + 1) / 4)});
`ifdef OCX_TLX_ARBQ_PARITY_EN
      chk($sformatf("drain%0d parity_err", k), 64'(parity_err), 64'h0);
`endif
    end
    tick();
    chk("drained out_valid", 64'(out_valid), 64'h0);
    chk("drained in_ready", 64'(in_ready), 64'hF);

    // reset with FIFOs half full
    drive(0, 4'b1111, 8'h20, 0);
    tick();
    drive(0, 4'b1111, 8'h21, 0);
    tick();
    drive(1, 4'b1111, 8'h22, 1);
    tick();
    chk("mid-reset out_valid", 64'(out_valid), 64'h0);
    chk("mid-reset in_ready", 64'(in_ready), 64'h0);
    chk("mid-reset out_chan", 64'(out_chan), 64'h0);
    drive(0, 4'b0000, 8'h00, 1);
    tick();
    chk("post-reset out_valid", 64'(out_valid), 64'h0);
    chk("post-reset in_ready", 64'(in_ready), 64'hF);
    drive(0, 4'b0011, 8'h30, 1);
    tick();
    chk("post-reset push out_valid", 64'(out_valid), 64'h0);
    drive(0, 4'b0000, 8'h00, 1);
    tick();
    chk("first grant out_chan", 64'(out_chan), 64'h0);
    chk("first grant out_data", out_data, 64'h0030);
    tick();
    chk("second grant out_chan", 64'(out_chan), 64'h1);
    chk("second grant out_data", out_data, 64'h0130);
    tick();
    chk("idle out_valid", 64'(out_valid), 64'h0);

`ifdef OCX_TLX_ARBQ_PARITY_EN
    drive(0, 4'b0100, 8'h40, 0);
    tick();
    drive(0, 4'b0010, 8'h41, 0);
    tick();
    chk("clean load parity_err", 64'(parity_err), 64'h0);
    chk("clean load out_chan", 64'(out_chan), 64'h2);
    drive(0, 4'b0000, 8'h00, 0);
    dut.g_chan[1].u_fifo.r_mem[1][3] = ~dut.g_chan[1].u_fifo.r_mem[1][3];
    drive(0, 4'b0000, 8'h00, 1);
    tick();
    chk("corrupt load parity_err", 64'(parity_err), 64'h1);
    chk("corrupt load out_data", out_data, 64'h0149);
    tick();
    chk("parity_err pulse end", 64'(parity_err), 64'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
